// File: rtl/ddr3_refresh_scheduler.sv
// rtl/ddr3_refresh_scheduler.sv - DDR3 auto-refresh scheduler with debt tracking (optional DDR3_REF_BURST_EN)
module ddr3_refresh_scheduler #(
    parameter int TREFI_CLK = 1560,
    parameter int TRP_CLK   = 8,
    parameter int TRFC_CLK  = 64,
    parameter int MAX_DEBT  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       cmd_pending,
    input  logic       pl_idle,
    output logic       cmd_allow,
    output logic       ref_busy,
    output logic       csbar,
    output logic       rasbar,
    output logic       casbar,
    output logic       webar,
    output logic       a10,
    output logic [3:0] debt,
    output logic       overflow
);

    localparam int IW   = (TREFI_CLK > 1) ? $clog2(TREFI_CLK) : 1;
    localparam int PMAX = (TRFC_CLK > TRP_CLK) ? TRFC_CLK : TRP_CLK;
    localparam int CW   = $clog2(PMAX + 2);

    // command pin encodings {cs, ras, cas, we}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_DES = 4'b1111;

    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_PRE, S_TRP, S_REF, S_TRFC} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IW-1:0]  r_ivl;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_limit;
    logic [3:0]     r_debt;
    logic [3:0]     w_debt_next;
    logic           r_overflow;
    logic [3:0]     r_cmd;
    logic           r_a10;
    logic           r_busy;
    logic           r_allow;
    logic           w_inc;
    logic           w_dec;
    logic           w_last;
    logic [3:0]     w_cmd;
    logic           w_a10;
    logic           w_busy;
    logic           w_allow;

    assign w_inc = ready && (r_ivl == IW'(TREFI_CLK - 1));

    // next state, debt arithmetic and the registered-output values for that next state
    always_comb begin
        w_next      = r_state;
        w_limit     = '0;
        w_cmd       = CMD_NOP;
        w_a10       = 1'b0;
        w_busy      = 1'b0;
        w_allow     = 1'b0;
        w_debt_next = r_debt;
        unique case (r_state)
            S_PRE, S_REF: w_limit = CW'(1);
            S_TRP:        w_limit = CW'(TRP_CLK - 1);
            S_TRFC:       w_limit = CW'(TRFC_CLK - 1);
            default:      w_limit = '0;
        endcase
        w_last = (r_cnt == w_limit);
        if (!ready) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (r_debt != 4'd0 && (!cmd_pending || r_debt >= 4'(MAX_DEBT))) w_next = S_DRAIN;
                S_DRAIN: if (pl_idle) w_next = S_PRE;
                S_PRE:   if (w_last) w_next = S_TRP;
                S_TRP:   if (w_last) w_next = S_REF;
                S_REF:   if (w_last) w_next = S_TRFC;
                S_TRFC: begin
                    if (w_last) begin
`ifdef DDR3_REF_BURST_EN
                        w_next = (r_debt != 4'd0) ? S_REF : S_IDLE;
`else
                        w_next = S_IDLE;
`endif
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
        w_dec = (w_next == S_REF) && (r_state != S_REF);
        if (w_inc && !w_dec) begin
            if (r_debt != 4'hF) w_debt_next = r_debt + 4'd1;
        end else if (w_dec && !w_inc) begin
            if (r_debt != 4'h0) w_debt_next = r_debt - 4'd1;
        end
        unique case (w_next)
            S_PRE:  begin w_cmd = CMD_PRE; w_a10 = 1'b1; end
            S_REF:  w_cmd = CMD_REF;
            default: w_cmd = CMD_NOP;
        endcase
        w_busy  = (w_next == S_PRE) || (w_next == S_TRP) || (w_next == S_REF) || (w_next == S_TRFC);
        w_allow = (w_next == S_IDLE) && (w_debt_next < 4'(MAX_DEBT));
    end

    // state register, counters, debt and registered command outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ivl      <= '0;
            r_cnt      <= '0;
            r_debt     <= 4'd0;
            r_overflow <= 1'b0;
            r_cmd      <= CMD_DES;
            r_a10      <= 1'b0;
            r_busy     <= 1'b0;
            r_allow    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (!ready || w_inc) r_ivl <= '0;
            else                 r_ivl <= r_ivl + IW'(1);
            if (w_next != r_state || r_state == S_IDLE || r_state == S_DRAIN) r_cnt <= '0;
            else                                                              r_cnt <= r_cnt + CW'(1);
            r_debt <= w_debt_next;
            if (w_inc && r_debt == 4'(MAX_DEBT)) r_overflow <= 1'b1;
            r_cmd   <= w_cmd;
            r_a10   <= w_a10;
            r_busy  <= w_busy;
            r_allow <= w_allow;
        end
    end

    assign csbar     = r_cmd[3];
    assign rasbar    = r_cmd[2];
    assign casbar    = r_cmd[1];
    assign webar     = r_cmd[0];
    assign a10       = r_a10;
    assign ref_busy  = r_busy;
    assign cmd_allow = r_allow;
    assign debt      = r_debt;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ddr3_refresh_scheduler.sv
// tb/tb_ddr3_refresh_scheduler.sv - self-checking bench for ddr3_refresh_scheduler
module tb_ddr3_refresh_scheduler;

    logic       clk = 1'b0;
    logic       reset, ready, cmd_pending, pl_idle;
    logic       cmd_allow, ref_busy, csbar, rasbar, casbar, webar, a10, overflow;
    logic [3:0] debt;

    ddr3_refresh_scheduler #(.TREFI_CLK(100), .TRP_CLK(8), .TRFC_CLK(64), .MAX_DEBT(8)) dut (
        .clk(clk), .reset(reset), .ready(ready), .cmd_pending(cmd_pending), .pl_idle(pl_idle),
        .cmd_allow(cmd_allow), .ref_busy(ref_busy), .csbar(csbar), .rasbar(rasbar),
        .casbar(casbar), .webar(webar), .a10(a10), .debt(debt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tick;
        logic [3:0] pins;
        logic       a10;
        logic       busy;
        logic       allow;
        logic [3:0] debt;
    } vec_t;

    vec_t tbl[13];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   t;

    function automatic logic [3:0] pins();
        return {csbar, rasbar, casbar, webar};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at tick %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        reset = 1'b1; ready = 1'b0; cmd_pending = 1'b0; pl_idle = 1'b1;
        repeat (3) tick();
        reset = 1'b0; ready = 1'b1;
        t = 0;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    initial begin
        int   idx, nbusy, npre, nref, exp_pre;
        logic [3:0] prev;
        vec_t e;

        tbl[0]  = '{1,   4'b0111, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[1]  = '{99,  4'b0111, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[2]  = '{100, 4'b0111, 1'b0, 1'b0, 1'b1, 4'd1};
        tbl[3]  = '{101, 4'b0111, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[4]  = '{102, 4'b0010, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[5]  = '{103, 4'b0010, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[6]  = '{104, 4'b0111, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[7]  = '{111, 4'b0111, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[8]  = '{112, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[9]  = '{113, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[10] = '{114, 4'b0111, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[11] = '{177, 4'b0111, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[12] = '{178, 4'b0111, 1'b0, 1'b0, 1'b1, 4'd0};

        t = 0;
        reset = 1'b1; ready = 1'b0; cmd_pending = 1'b0; pl_idle = 1'b1;
        repeat (3) tick();
        chk("rst_pins", pins(), 4'b1111);
        chk("rst_a10", a10, 1'b0);
        chk("rst_busy", ref_busy, 1'b0);
        chk("rst_allow", cmd_allow, 1'b0);
        chk("rst_debt", debt, 4'd0);
        chk("rst_ovf", overflow, 1'b0);

        // basic single refresh sequence, scoreboard-checked at key ticks
        do_reset();
        idx = 0; nbusy = 0; npre = 0; nref = 0;
        while (t < 199) begin
            tick();
            if (idx < 13 && tbl[idx].tick == t) begin
                exp_q.push_back(tbl[idx]);
                idx++;
            end
            if (ref_busy) nbusy++;
            if (pins() == 4'b0010) npre++;
            if (pins() == 4'b0001) nref++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("seq_pins@%0d", e.tick), pins(), e.pins);
                chk($sformatf("seq_a10@%0d", e.tick), a10, e.a10);
                chk($sformatf("seq_busy@%0d", e.tick), ref_busy, e.busy);
                chk($sformatf("seq_allow@%0d", e.tick), cmd_allow, e.allow);
                chk($sformatf("seq_debt@%0d", e.tick), debt, e.debt);
            end
        end
        chk("busy_cycles", nbusy, 76);
        chk("pre_cycles", npre, 2);
        chk("ref_cycles", nref, 2);

        // postponed refreshes reach MAX_DEBT, command fetch is blocked, refresh forced
        do_reset();
        cmd_pending = 1'b1; pl_idle = 1'b0;
        run_to(799);
        chk("debt7", debt, 4'd7);
        chk("allow_before_max", cmd_allow, 1'b1);
        tick();
        chk("debt8", debt, 4'd8);
        chk("allow_at_max", cmd_allow, 1'b0);
        tick();
        chk("drain_allow", cmd_allow, 1'b0);
        chk("drain_busy", ref_busy, 1'b0);
        pl_idle = 1'b1;
        idx = 0;
        while (pins() != 4'b0001 && idx < 50) begin tick(); idx++; end
        chk("forced_ref_seen", pins(), 4'b0001);
        chk("forced_ref_debt", debt, 4'd7);
        chk("forced_ovf", overflow, 1'b0);

        // overflow is sticky; reset during TRFC clears everything
        do_reset();
        cmd_pending = 1'b1; pl_idle = 1'b0;
        run_to(899);
        chk("ovf_pre", overflow, 1'b0);
        chk("debt_pre_ovf", debt, 4'd8);
        tick();
        chk("ovf_set", overflow, 1'b1);
        chk("debt9", debt, 4'd9);
        run_to(1000);
        chk("ovf_sticky", overflow, 1'b1);
        chk("debt10", debt, 4'd10);
        pl_idle = 1'b1;
        run_to(1020);
        chk("trfc_busy", ref_busy, 1'b1);
        chk("trfc_pins", pins(), 4'b0111);
        chk("trfc_ovf", overflow, 1'b1);
        reset = 1'b1;
        tick();
        chk("mid_rst_pins", pins(), 4'b1111);
        chk("mid_rst_a10", a10, 1'b0);
        chk("mid_rst_busy", ref_busy, 1'b0);
        chk("mid_rst_allow", cmd_allow, 1'b0);
        chk("mid_rst_debt", debt, 4'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        reset = 1'b0;

        // debt=3: burst vs separate sequences
        do_reset();
        cmd_pending = 1'b1; pl_idle = 1'b0;
        run_to(300);
        chk("debt3", debt, 4'd3);
        cmd_pending = 1'b0; pl_idle = 1'b1;
        npre = 0; nref = 0; idx = 0;
        prev = pins();
        while (nref < 3 && idx < 400) begin
            tick(); idx++;
            if (pins() == 4'b0010 && prev != 4'b0010) npre++;
            if (pins() == 4'b0001 && prev != 4'b0001) nref++;
            prev = pins();
        end
`ifdef DDR3_REF_BURST_EN
        exp_pre = 1;
`else
        exp_pre = 3;
`endif
        chk("burst_ref_count", nref, 3);
        chk("burst_pre_count", npre, exp_pre);

        // interval wrap coinciding with REF entry, then ready dropped mid-sequence
        do_reset();
        cmd_pending = 1'b0; pl_idle = 1'b0;
        run_to(189);
        chk("wait_drain_busy", ref_busy, 1'b0);
        pl_idle = 1'b1;
        run_to(199);
        chk("pre_wrap_debt", debt, 4'd1);
        tick();
        chk("wrap_ref_pins", pins(), 4'b0001);
        chk("wrap_ref_debt", debt, 4'd1);
        run_to(205);
        ready = 1'b0;
        tick();
        chk("ready_drop_busy", ref_busy, 1'b0);
        chk("ready_drop_pins", pins(), 4'b0111);
        chk("ready_drop_debt", debt, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddr3_refresh_scheduler.md
DDR3_REFRESH_SCHEDULER -- requirements
Module: ddr3_refresh_scheduler

Interface
REQ-001 SHALL have parameter TREFI_CLK, default 1560, meaning refresh interval in clk cycles.
REQ-002 SHALL have parameter TRP_CLK, default 8, meaning precharge-to-refresh wait in clk cycles.
REQ-003 SHALL have parameter TRFC_CLK, default 64, meaning refresh-to-next-command wait in clk cycles.
REQ-004 SHALL have parameter MAX_DEBT, default 8, meaning the postponed-refresh count at which refresh is forced.
REQ-005 SHALL have port clk, input, 1, meaning the system clock; reset is synchronous, active-high, and named reset.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port ready, input, 1, meaning initialization is complete.
REQ-008 SHALL have port cmd_pending, input, 1, meaning the command FIFO is non-empty.
REQ-009 SHALL have port pl_idle, input, 1, meaning the processing logic has no access in flight.
REQ-010 SHALL have port cmd_allow, output, 1, meaning the processing logic may fetch a new command.
REQ-011 SHALL have port ref_busy, output, 1, meaning the scheduler owns the command bus (mux select).
REQ-012 SHALL have ports csbar, rasbar, casbar, webar, output, 1 each, meaning the DDR3 command pins.
REQ-013 SHALL have port a10, output, 1, meaning address bit 10, set to 1 for PRECHARGE ALL.
REQ-014 SHALL have port debt, output, 4, meaning the count of owed refreshes.
REQ-015 SHALL have port overflow, output, 1, meaning sticky: debt exceeded MAX_DEBT.

Function
REQ-016 SHALL run the interval counter only while ready=1: it counts 0..TREFI_CLK-1, wraps, and increments debt on each wrap.
REQ-017 SHALL saturate debt at 15 and set overflow when an increment occurs with debt already equal to MAX_DEBT.
REQ-018 SHALL implement states IDLE, DRAIN, PRE, TRP, REF, TRFC.
REQ-019 SHALL transition IDLE->DRAIN when debt>0 and either (a) cmd_pending=0 or (b) debt>=MAX_DEBT.
REQ-020 SHALL drive cmd_allow=0 in every state except IDLE, and also in IDLE when debt>=MAX_DEBT.
REQ-021 SHALL wait in DRAIN until pl_idle=1, then go to PRE.
REQ-022 SHALL drive PRE (csbar=0, rasbar=0, casbar=1, webar=0, a10=1) for exactly 2 clk cycles in state PRE, then go to TRP.
REQ-023 SHALL hold NOP in TRP for TRP_CLK cycles, then go to REF.
REQ-024 SHALL drive REFRESH (csbar=0, rasbar=0, casbar=0, webar=1) for exactly 2 clk cycles in state REF, decrement debt once on entry, then go to TRFC.
REQ-025 SHALL hold NOP (csbar=0, rasbar=1, casbar=1, webar=1, a10=0) in TRFC for TRFC_CLK cycles, then go to IDLE.
REQ-026 SHALL drive NOP in all other states.
REQ-027 SHALL assert ref_busy in PRE, TRP, REF and TRFC only.
REQ-028 SHALL apply both changes in the same cycle when a debt increment and a decrement coincide (net zero).
REQ-029 SHALL return to IDLE on the next clk with the counter cleared if ready falls mid-sequence; debt SHALL be retained.

Reset
REQ-030 SHALL, on reset=1: set state IDLE, interval counter 0, debt 0, overflow 0, cmd_allow 0, ref_busy 0, csbar/rasbar/casbar/webar 1, and a10 0.
REQ-031 SHALL take effect within one clk of reset assertion regardless of the current state.

Configuration
REQ-032 SHALL, when DDR3_REF_BURST_EN is defined, go from TRFC back to REF while debt>0, issuing all owed refreshes in one sequence.
REQ-033 SHALL, when DDR3_REF_BURST_EN is undefined, issue exactly one REFRESH per PRE sequence and then return to IDLE.

Verification
REQ-034 SHALL cover: ready=1, cmd_pending=0, pl_idle=1, TREFI_CLK=100 -> PRE at cycle 101-102, REF at cycle 111-112, debt goes 1->0, ref_busy high for 76 cycles.
REQ-035 SHALL cover: cmd_pending held at 1 for 8 intervals -> debt=8, cmd_allow=0 from the 8th wrap, and a refresh is forced once pl_idle=1.
REQ-036 SHALL cover: cmd_pending=1 and pl_idle=0 for 9 intervals -> overflow=1 and stays 1 until reset.
REQ-037 SHALL cover: reset asserted during TRFC -> all outputs return to their reset values on the next clk, and debt=0.
REQ-038 SHALL cover: debt=3 with DDR3_REF_BURST_EN defined -> one PRE and three REF commands; undefined -> three separate PRE+REF sequences.
REQ-039 SHALL cover: a wrap coinciding with REF entry -> debt unchanged.
